// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: samples 11-bit frames on mouse-clock falling edges.
// Optional clock glitch filter enabled by defining MOUSE_RX_GLITCH_FILTER_EN.
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_CTR_W       = 16,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic       BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic [7:0] BYTE,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          ctr_q, ctr_d;
  logic [TO_CTR_W-1:0] to_q, to_d;
  logic                par_q, par_d, stp_q, stp_d;
  logic [7:0]          byte_d;
  logic [1:0]          err_d;
  logic                rd_d;

  logic clk_s1, clk_s2, dat_s1, dat_s2, clk_lvl, clk_prev, fall;

  // Synchronizers idle high so reset release never fakes a falling edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      clk_s1   <= CLK_MOUSE_IN;
      clk_s2   <= clk_s1;
      dat_s1   <= DATA_MOUSE_IN;
      dat_s2   <= dat_s1;
      clk_prev <= clk_lvl;
    end
  end

`ifdef MOUSE_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_s2;
`endif

  assign fall = clk_prev & ~clk_lvl;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    ctr_d   = ctr_q;
    to_d    = to_q;
    par_d   = par_q;
    stp_d   = stp_q;
    byte_d  = BYTE;
    err_d   = BYTE_ERROR_CODE;
    rd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall && READ_ENABLE && !dat_s2) begin
          state_d = S_DATA;
          ctr_d   = '0;
          to_d    = '0;
        end
      end
      S_DATA, S_PARITY, S_STOP: begin
        if (fall) begin
          to_d = '0;
          case (state_q)
            S_DATA: begin
              shift_d[ctr_q] = dat_s2;
              ctr_d          = ctr_q + 3'd1;
              if (ctr_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
              par_d   = ~(^{shift_q, dat_s2});
              state_d = S_STOP;
            end
            default: begin
              stp_d   = ~dat_s2;
              state_d = S_DONE;
            end
          endcase
        end else if (to_q == TO_CTR_W'(TIMEOUT_CYCLES - 1)) begin
          // Mouse stopped clocking mid-frame: drop the partial byte.
          state_d = S_IDLE;
          to_d    = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_DONE: begin
        byte_d  = shift_q;
        err_d   = {stp_q, par_q};
        rd_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        shift_d = '0;
        ctr_d   = '0;
        to_d    = '0;
        par_d   = 1'b0;
        stp_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q         <= S_IDLE;
      shift_q         <= '0;
      ctr_q           <= '0;
      to_q            <= '0;
      par_q           <= 1'b0;
      stp_q           <= 1'b0;
      BYTE            <= 8'h00;
      BYTE_ERROR_CODE <= 2'b00;
      BYTE_READ       <= 1'b0;
      BUSY            <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      ctr_q           <= ctr_d;
      to_q            <= to_d;
      par_q           <= par_d;
      stp_q           <= stp_d;
      BYTE            <= byte_d;
      BYTE_ERROR_CODE <= err_d;
      BYTE_READ       <= rd_d;
      BUSY            <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

endmodule

// File: tb/tb_mouse_receiver.sv
// Scoreboard bench for mouse_receiver: frames are driven bit by bit, expected
// {err,byte} pushed at drive time and popped on each BYTE_READ pulse.
module tb_mouse_receiver;
  localparam int H = 20;  // mouse clock half period in CLK cycles

  logic       CLK = 1'b0, RESET = 1'b1;
  logic       mclk = 1'b1, mdat = 1'b1, re = 1'b1;
  logic       BYTE_READ, BUSY;
  logic [1:0] BYTE_ERROR_CODE;
  logic [7:0] BYTE;

  int n_cmp = 0, n_bad = 0;
  logic [9:0] exp_q[$];

  mouse_receiver dut (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(mclk), .DATA_MOUSE_IN(mdat),
    .READ_ENABLE(re), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE(BYTE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic par, input logic stp);
    return {stp, par, b, 1'b0};
  endfunction

  // Protocol-level model: edge samples (a glitch duplicates one bit), first 11 form the frame.
  function automatic logic [9:0] model(input logic [10:0] f, input int g);
    logic [11:0] s;
    int k;
    s = '0;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      s[k] = f[i];
      k++;
      if (i == g) begin
        s[k] = f[i];
        k++;
      end
    end
    return {~s[10], ~(^s[9:1]), s[8:1]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_at,
                           input bit drop_re);
    for (int i = 0; i < nbits; i++) begin
      mdat = f[i];
      cyc(H / 2);
      if (i == glitch_at) begin
        mclk = 1'b0;
        cyc(3);
        mclk = 1'b1;
      end
      cyc(H / 2);
      mclk = 1'b0;
      cyc(H);
      mclk = 1'b1;
      if (drop_re && i == 0) re = 1'b0;
    end
    mdat = 1'b1;
    cyc(H);
  endtask

  task automatic frame(input logic [10:0] f, input int glitch_at, input bit expect_rx);
    if (expect_rx) exp_q.push_back(model(f, glitch_at));
    send_bits(f, 11, glitch_at, 1'b0);
    cyc(10);
    chk("pending", exp_q.size(), 0);
    chk("busy_idle", BUSY, 0);
  endtask

  always @(negedge CLK) begin
    logic [9:0] e;
    if (!RESET && BYTE_READ) begin
      chk("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte", BYTE, e[7:0]);
        chk("err", BYTE_ERROR_CODE, e[9:8]);
      end
    end
  end

  initial begin
    logic [10:0] f;
    int g;
    cyc(4);
    chk("rst_byte", BYTE, 8'h00);
    chk("rst_err", BYTE_ERROR_CODE, 2'b00);
    chk("rst_rd", BYTE_READ, 0);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0;
    cyc(5);

    // Clean frame, with a BUSY check right after the start bit
    f = mk(8'hFA, 1'b1, 1'b1);
    exp_q.push_back(model(f, -1));
    send_bits(f, 1, -1, 1'b0);
    chk("busy_mid", BUSY, 1);
    send_bits(f >> 1, 10, -1, 1'b0);
    cyc(10);
    chk("pending", exp_q.size(), 0);
    chk("busy_idle", BUSY, 0);
    chk("fa_hold", BYTE, 8'hFA);

    frame(mk(8'hAA, 1'b0, 1'b1), -1, 1'b1);  // parity error
    frame(mk(8'h08, 1'b0, 1'b0), -1, 1'b1);  // stop error

    // Timeout after start + 4 data bits
    send_bits(mk(8'h55, 1'b1, 1'b1), 5, -1, 1'b0);
    chk("busy_partial", BUSY, 1);
    cyc(60000);
    chk("to_busy", BUSY, 0);
    chk("to_byte", BYTE, 8'h08);
    chk("to_err", BYTE_ERROR_CODE, 2'b10);
    frame(mk(8'h08, 1'b0, 1'b1), -1, 1'b1);

    // Receiver disabled: frame ignored
    re = 1'b0;
    frame(mk(8'hF4, 1'b0, 1'b1), -1, 1'b0);
    chk("dis_byte", BYTE, 8'h08);
    re = 1'b1;
    // Enable dropped after start bit: frame still completes
    f = mk(8'h3C, 1'b1, 1'b1);
    exp_q.push_back(model(f, -1));
    send_bits(f, 11, -1, 1'b1);
    cyc(10);
    chk("pending_re", exp_q.size(), 0);
    chk("re_byte", BYTE, 8'h3C);
    re = 1'b1;

    // Reset after the 5th data bit
    send_bits(mk(8'hC3, 1'b1, 1'b1), 6, -1, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("mrst_byte", BYTE, 8'h00);
    chk("mrst_err", BYTE_ERROR_CODE, 2'b00);
    chk("mrst_busy", BUSY, 0);
    cyc(3);
    RESET = 1'b0;
    cyc(5);
    frame(mk(8'hFF, 1'b1, 1'b1), -1, 1'b1);

    // Short clock glitch mid-byte
`ifdef MOUSE_RX_GLITCH_FILTER_EN
    g = -1;
`else
    g = 5;
`endif
    f = mk(8'h5A, 1'b1, 1'b1);
    exp_q.push_back(model(f, g));
    send_bits(f, 11, 5, 1'b0);
    cyc(10);
    chk("pending_glitch", exp_q.size(), 0);
    chk("busy_end", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
